// File: rtl/potential_decay_engine.sv
// potential_decay_engine
// Sweeps a bank of membrane potentials held in an external RAM. Each
// potential is read, decayed (LIF shift-sum or quadratic) with saturation,
// and written back in address order, one neuron per cycle when hold is low.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start; no reads or writes issued
// ST_SWEEP   | issuing reads 0..NUM_NEURONS-1, writes retire behind them
// ST_DRAIN   | all reads issued; retiring the remaining landed potentials
module potential_decay_engine #(
  parameter int NUM_NEURONS = 256,
  parameter int ADDR_WIDTH  = 8,
  parameter int WIDTH       = 32,
  parameter int FRAC_BITS   = 16,
  parameter int DECAY_TERMS = 4
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   start,
  input  logic [1:0]             model,
  input  logic [DECAY_TERMS-1:0] decay_mask,
  input  logic                   hold,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
  input  logic [WIDTH-1:0]       mem_rd_data,
  output logic                   mem_wr_en,
  output logic [ADDR_WIDTH-1:0]  mem_wr_addr,
  output logic [WIDTH-1:0]       mem_wr_data,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // LIF accumulator: room for DECAY_TERMS terms plus a guard bit
  localparam int ACC_W = WIDTH + $clog2(DECAY_TERMS) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_NEURONS - 1);
  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]             state_q;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q;
  logic                   quad_q;
  logic [DECAY_TERMS-1:0] mask_q;
  logic                   inflight_q;
  logic [ADDR_WIDTH-1:0]  inflight_addr_q;
  logic                   finish_q;

  // two-entry landing FIFO of {addr, data}
  logic [ADDR_WIDTH-1:0]  fifo_addr_q [2];
  logic [WIDTH-1:0]       fifo_data_q [2];
  logic                   fifo_rd_idx_q;
  logic                   fifo_wr_idx_q;
  logic [1:0]             fifo_occ_q;

  logic                   start_accept;
  logic                   pop;
  logic [2:0]             occ_ahead;
  logic                   rd_issue;
  logic [ADDR_WIDTH-1:0]  head_addr;
  logic                   last_pop;

  logic signed [WIDTH-1:0]     head_v;
  logic signed [WIDTH-1:0]     lif_term;
  logic signed [ACC_W-1:0]     lif_acc;
  logic [WIDTH-1:0]            lif_res;
  logic signed [2*WIDTH-1:0]   sq_ext;
  logic signed [2*WIDTH-1:0]   sq_sh;
  logic [WIDTH-1:0]            quad_res;
  logic [WIDTH-1:0]            f_next;

  // Issue/retire control. Occupancy counts what the FIFO will hold after this
  // edge's push and pop, so a read is only issued when its data has a slot.
  always_comb begin
    start_accept = start && (state_q == ST_IDLE) && !busy;
    pop          = (fifo_occ_q != 2'd0) && !hold;
    occ_ahead    = {1'b0, fifo_occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_issue     = (state_q == ST_SWEEP) && !hold && (occ_ahead < 3'd2);
    head_addr    = fifo_addr_q[fifo_rd_idx_q];
    last_pop     = (state_q == ST_DRAIN) && pop && (head_addr == LAST_ADDR);
  end

  assign mem_rd_en   = rd_issue;
  assign mem_rd_addr = rd_ptr_q;

  // Decay transfer function applied to the FIFO head
  always_comb begin
    head_v   = fifo_data_q[fifo_rd_idx_q];
    lif_term = '0;
    lif_acc  = '0;
    for (int k = 0; k < DECAY_TERMS; k++) begin
      lif_term = head_v >>> k;
      if (mask_q[k]) begin
        lif_acc = lif_acc + {{(ACC_W-WIDTH){lif_term[WIDTH-1]}}, lif_term};
      end
    end
    if (!lif_acc[ACC_W-1] && (|lif_acc[ACC_W-2:WIDTH-1])) begin
      lif_res = POS_MAX;
    end else if (lif_acc[ACC_W-1] && !(&lif_acc[ACC_W-2:WIDTH-1])) begin
      lif_res = NEG_MIN;
    end else begin
      lif_res = lif_acc[WIDTH-1:0];
    end

    // a square is never negative, so only the upper bound can be exceeded
    sq_ext = {{WIDTH{head_v[WIDTH-1]}}, head_v};
    sq_sh  = (sq_ext * sq_ext) >>> FRAC_BITS;
    if (|sq_sh[2*WIDTH-1:WIDTH-1]) begin
      quad_res = POS_MAX;
    end else begin
      quad_res = sq_sh[WIDTH-1:0];
    end

    if (quad_q) begin
      f_next = quad_res;
    end else if (mask_q == '0) begin
      f_next = head_v;
    end else begin
      f_next = lif_res;
    end
  end

  // Sweep FSM
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_accept) state_q <= ST_SWEEP;
        ST_SWEEP: if (rd_issue && (rd_ptr_q == LAST_ADDR)) state_q <= ST_DRAIN;
        ST_DRAIN: if (last_pop) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Mode latches, read pointer and in-flight read tracking
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      quad_q          <= 1'b0;
      mask_q          <= '0;
      rd_ptr_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      if (start_accept) begin
        quad_q   <= (model == 2'b01);
        mask_q   <= decay_mask;
        rd_ptr_q <= '0;
      end else if (rd_issue) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      inflight_q <= rd_issue;
      if (rd_issue) inflight_addr_q <= rd_ptr_q;
    end
  end

  // Landing FIFO: returned data is pushed unconditionally one cycle after its read
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < 2; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      fifo_rd_idx_q <= 1'b0;
      fifo_wr_idx_q <= 1'b0;
      fifo_occ_q    <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_addr_q[fifo_wr_idx_q] <= inflight_addr_q;
        fifo_data_q[fifo_wr_idx_q] <= mem_rd_data;
        fifo_wr_idx_q              <= ~fifo_wr_idx_q;
      end
      if (pop) fifo_rd_idx_q <= ~fifo_rd_idx_q;
      fifo_occ_q <= fifo_occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  // Registered write port; address/data hold between writes
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_wr_en <= pop;
      if (pop) begin
        mem_wr_addr <= head_addr;
        mem_wr_data <= f_next;
      end
    end
  end

  // busy/done: both change the cycle after the last write is registered
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      finish_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      finish_q <= last_pop;
      done     <= finish_q;
      if (start_accept) begin
        busy <= 1'b1;
      end else if (finish_q) begin
        busy <= 1'b0;
      end
    end
  end

endmodule
